// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports, one synchronous write
// port, a hard-wired zero register, and a post-reset sequencer that initialises
// one entry per cycle before raising ready.
//
// Ports:
//   clk            clock; all state updates on posedge
//   reset          synchronous, active-low reset
//   we3/wa3/wd3    write enable / address / data (honoured only in RUN)
//   ra1/ra2        read addresses
//   rd1/rd2        combinational read data (0 while not ready or at ZR_IDX)
//   ready          high once every entry has been initialised
//
// Optional build macro REGFILE_BYPASS_EN: same-cycle write-through forwarding
// from the write port to both read ports.

module regfile_param #(
  parameter int N          = 64,
  parameter int DEPTH      = 32,
  parameter int ZR_IDX     = DEPTH - 1,
  parameter int INIT_INDEX = 1,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we3,
  input  logic [AW-1:0] wa3,
  input  logic [N-1:0]  wd3,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [N-1:0]  rd1,
  output logic [N-1:0]  rd2,
  output logic          ready
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [AW-1:0] ZR   = AW'(ZR_IDX);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [0:0]    state;
  logic [AW-1:0] init_cnt;
  logic [N-1:0]  init_val;
  logic [N-1:0]  rf [DEPTH];

  // Value written by the sequencer for the current entry. The counter is
  // zero-extended (or truncated when N < AW) to the data width.
  always_comb begin
    init_val = '0;
    if (INIT_INDEX == 1 && init_cnt != ZR) begin
      init_val = N'(init_cnt);
    end
  end

  // Control: the last init write, the move to RUN and the rise of ready all
  // happen on the same edge, so INIT lasts exactly DEPTH cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      ready    <= 1'b0;
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + AW'(1);
      if (init_cnt == LAST) begin
        state <= ST_RUN;
        ready <= 1'b1;
      end
    end
  end

  // Storage: no array write while reset is asserted; the user write port is
  // ignored during INIT and writes to the zero register are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == ST_INIT) begin
        rf[init_cnt] <= init_val;
      end else if (we3 && wa3 != ZR) begin
        rf[wa3] <= wd3;
      end
    end
  end

  // Read port 1. ready is only ever high in RUN, so it alone gates forwarding.
  always_comb begin
    rd1 = '0;
    if (ready && ra1 != ZR) begin
      rd1 = rf[ra1];
`ifdef REGFILE_BYPASS_EN
      if (we3 && wa3 == ra1) begin
        rd1 = wd3;
      end
`endif
    end
  end

  // Read port 2, identical to port 1.
  always_comb begin
    rd2 = '0;
    if (ready && ra2 != ZR) begin
      rd2 = rf[ra2];
`ifdef REGFILE_BYPASS_EN
      if (we3 && wa3 == ra2) begin
        rd2 = wd3;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: a default instance (N=64, DEPTH=32, ZR=31, index init)
// and a small instance (N=32, DEPTH=16, ZR=0, zero init) share clock and reset.
// Directed steps followed by randomized traffic, checked against array models.

module tb_regfile_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        we3;
  logic [4:0]  wa3, ra1, ra2;
  logic [63:0] wd3, rd1, rd2;
  logic        ready;

  logic        we_s;
  logic [3:0]  wa_s, ra1_s, ra2_s;
  logic [31:0] wd_s, rd1_s, rd2_s;
  logic        ready_s;

  int checks = 0;
  int errors = 0;

  // Reference models: contents plus "initialised" flag and edge count since release.
  logic [63:0] mdl [32];
  bit          mrdy = 1'b0;
  int          mcnt = 0;
  logic [31:0] smdl [16];
  bit          srdy = 1'b0;
  int          scnt = 0;

  regfile_param dut (
    .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .ready(ready)
  );

  regfile_param #(.N(32), .DEPTH(16), .ZR_IDX(0), .INIT_INDEX(0)) dut_s (
    .clk(clk), .reset(reset), .we3(we_s), .wa3(wa_s), .wd3(wd_s),
    .ra1(ra1_s), .ra2(ra2_s), .rd1(rd1_s), .rd2(rd2_s), .ready(ready_s)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_rd(input logic [4:0] ra);
    if (!mrdy || ra == 5'd31) return 64'd0;
`ifdef REGFILE_BYPASS_EN
    if (we3 && wa3 == ra) return wd3;
`endif
    return mdl[ra];
  endfunction

  function automatic logic [31:0] sexp_rd(input logic [3:0] ra);
    if (!srdy || ra == 4'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (we_s && wa_s == ra) return wd_s;
`endif
    return smdl[ra];
  endfunction

  task automatic check_all();
    chk("rd1", rd1, exp_rd(ra1));
    chk("rd2", rd2, exp_rd(ra2));
    chk("ready", 64'(ready), 64'(mrdy));
    chk("s_rd1", 64'(rd1_s), 64'(sexp_rd(ra1_s)));
    chk("s_rd2", 64'(rd2_s), 64'(sexp_rd(ra2_s)));
    chk("s_ready", 64'(ready_s), 64'(srdy));
  endtask

  // Settle combinational outputs after an input change, then compare.
  task automatic peek();
    #1;
    check_all();
  endtask

  // One clock edge: sample the inputs the DUT sees, advance the models, compare.
  task automatic cyc();
    logic        r  = reset;
    logic        w  = we3;
    logic [4:0]  a  = wa3;
    logic [63:0] d  = wd3;
    logic        ws = we_s;
    logic [3:0]  as = wa_s;
    logic [31:0] ds = wd_s;
    @(posedge clk);
    #2;
    if (!r) begin
      mrdy = 1'b0; mcnt = 0;
      srdy = 1'b0; scnt = 0;
    end else begin
      if (!mrdy) begin
        mcnt++;
        if (mcnt == 32) begin
          mrdy = 1'b1;
          for (int k = 0; k < 32; k++) mdl[k] = (k == 31) ? 64'd0 : 64'(k);
        end
      end else if (w && a != 5'd31) begin
        mdl[a] = d;
      end
      if (!srdy) begin
        scnt++;
        if (scnt == 16) begin
          srdy = 1'b1;
          for (int k = 0; k < 16; k++) smdl[k] = 32'd0;
        end
      end else if (ws && as != 4'd0) begin
        smdl[as] = ds;
      end
    end
    check_all();
  endtask

  initial begin
    reset = 1'b0; we3 = 1'b0; wa3 = '0; wd3 = '0; ra1 = '0; ra2 = '0;
    we_s = 1'b0; wa_s = '0; wd_s = '0; ra1_s = '0; ra2_s = '0;

    // Reset held for three edges.
    repeat (3) cyc();
    chk("reset_ready", 64'(ready), 64'd0);

    // Release; user writes to entry 3 during INIT cycles 0..5 must be ignored.
    reset = 1'b1; we3 = 1'b1; wa3 = 5'd3; wd3 = 64'd99;
    for (int i = 1; i <= 32; i++) begin
      if (i == 7) we3 = 1'b0;
      ra1 = 5'($urandom); ra2 = 5'($urandom);
      ra1_s = 4'($urandom); ra2_s = 4'($urandom);
      cyc();
      if (i == 31) chk("ready_before_last", 64'(ready), 64'd0);
    end
    chk("ready_after_32", 64'(ready), 64'd1);

    ra1 = 5'd5; ra2 = 5'd30; peek();
    chk("init_r5", rd1, 64'd5);
    chk("init_r30", rd2, 64'd30);
    ra1 = 5'd31; peek();
    chk("init_zr", rd1, 64'd0);
    ra1 = 5'd3; peek();
    chk("init_write_ignored", rd1, 64'd3);

    // Zero register write is discarded.
    we3 = 1'b1; wa3 = 5'd31; wd3 = 64'hDEAD; cyc();
    we3 = 1'b0; ra1 = 5'd31; ra2 = 5'd30; peek();
    chk("zr_read", rd1, 64'd0);
    chk("zr_other", rd2, 64'd30);

    // Write and read the same address in the same cycle.
    we3 = 1'b1; wa3 = 5'd7; wd3 = 64'h1234_5678; ra1 = 5'd7; peek();
`ifdef REGFILE_BYPASS_EN
    chk("same_cycle_pre", rd1, 64'h1234_5678);
`else
    chk("same_cycle_pre", rd1, 64'd7);
`endif
    cyc();
    we3 = 1'b0; peek();
    chk("same_cycle_post", rd1, 64'h1234_5678);

    // Reset in RUN re-initialises a modified entry.
    we3 = 1'b1; wa3 = 5'd4; wd3 = 64'd77; cyc();
    we3 = 1'b0; ra1 = 5'd4; peek();
    chk("run_write4", rd1, 64'd77);
    reset = 1'b0; cyc();
    reset = 1'b1;
    repeat (32) cyc();
    chk("reinit_ready", 64'(ready), 64'd1);
    chk("reinit_r4", rd1, 64'd4);

    // Reset mid-INIT restarts the sequence.
    reset = 1'b0; cyc();
    reset = 1'b1; repeat (10) cyc();
    reset = 1'b0; cyc();
    reset = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      cyc();
      if (i == 31) chk("midinit_not_ready", 64'(ready), 64'd0);
    end
    chk("midinit_ready", 64'(ready), 64'd1);

    // Small instance: all zero after init, ZR=0 discards, entry 15 stores.
    for (int k = 0; k < 16; k++) begin
      ra1_s = 4'(k); peek();
      chk("s_init_zero", 64'(rd1_s), 64'd0);
    end
    we_s = 1'b1; wa_s = 4'd0; wd_s = 32'd5; cyc();
    we_s = 1'b0; ra1_s = 4'd0; peek();
    chk("s_zr_write", 64'(rd1_s), 64'd0);
    we_s = 1'b1; wa_s = 4'd15; wd_s = 32'd9; cyc();
    we_s = 1'b0; ra1_s = 4'd15; peek();
    chk("s_r15", 64'(rd1_s), 64'd9);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 80) != 0);
      we3 = 1'($urandom); wa3 = 5'($urandom); wd3 = {$urandom, $urandom};
      ra1 = ($urandom_range(0, 3) == 0) ? wa3 : 5'($urandom);
      ra2 = 5'($urandom);
      we_s = 1'($urandom); wa_s = 4'($urandom); wd_s = $urandom;
      ra1_s = ($urandom_range(0, 3) == 0) ? wa_s : 4'($urandom);
      ra2_s = 4'($urandom);
      peek();
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
